// File: rtl/pad_input_conditioner_pkg.sv
// Shared constants and helpers for the pad input conditioner.
// Direction one-hot codes, raw line indices, button indices and the
// priority encoder used to turn debounced direction lines into a state.
package pad_pkg;

  localparam int unsigned DIR_W = 5;

  typedef logic [DIR_W-1:0] dir_t;

  localparam dir_t DIR_CENTER = 5'b00001;
  localparam dir_t DIR_LEFT   = 5'b00010;
  localparam dir_t DIR_RIGHT  = 5'b00100;
  localparam dir_t DIR_UP     = 5'b01000;
  localparam dir_t DIR_DOWN   = 5'b10000;

  // Positions inside the raw {down, up, right, left} direction vector.
  localparam int unsigned IDX_LEFT  = 0;
  localparam int unsigned IDX_RIGHT = 1;
  localparam int unsigned IDX_UP    = 2;
  localparam int unsigned IDX_DOWN  = 3;

  localparam int unsigned BTN_ATTACK = 0;
  localparam int unsigned BTN_PARRY  = 1;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // LEFT > RIGHT > UP > DOWN; nothing pressed is CENTER.
  function automatic dir_t encode_dir(input logic [3:0] dirs);
    dir_t res;
    if (dirs[IDX_LEFT])       res = DIR_LEFT;
    else if (dirs[IDX_RIGHT]) res = DIR_RIGHT;
    else if (dirs[IDX_UP])    res = DIR_UP;
    else if (dirs[IDX_DOWN])  res = DIR_DOWN;
    else                      res = DIR_CENTER;
    return res;
  endfunction

endpackage

// File: rtl/pad_input_conditioner_if.sv
// Controller pad bundle: raw pin lines in, conditioned direction/button
// signals and LED copy out.
//   master: drives raw lines, observes conditioned outputs (pins / bench side)
//   slave : the conditioner itself
interface pad_input_conditioner_if #(
  parameter int unsigned NUM_BUTTONS = 2
);
  import pad_pkg::*;

  logic [3:0]                   dir_raw;
  logic [NUM_BUTTONS-1:0]       btn_raw;
  dir_t                         dir_state;
  logic                         dir_change;
  logic [NUM_BUTTONS-1:0]       btn_level;
  logic [NUM_BUTTONS-1:0]       btn_press;
  logic [NUM_BUTTONS-1:0]       btn_release;
  logic [NUM_BUTTONS-1:0]       btn_held;
  logic [DIR_W+NUM_BUTTONS-1:0] led_outputs;

  modport master (
    output dir_raw, btn_raw,
    input  dir_state, dir_change, btn_level, btn_press, btn_release, btn_held, led_outputs
  );

  modport slave (
    input  dir_raw, btn_raw,
    output dir_state, dir_change, btn_level, btn_press, btn_release, btn_held, led_outputs
  );

endinterface

// File: rtl/pad_input_conditioner_debounce_channel.sv
// One raw controller line: 2-FF synchroniser followed by a debounce counter.
// Ports: clk, rst_n (async active-low), raw (asynchronous line), stable
// (debounced level, flips after DEBOUNCE_CYCLES consecutive differing cycles).
module debounce_channel #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_W           = 19
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic stable
);

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Any cycle where synced matches stable restarts the count, so only an
  // unbroken run of DEBOUNCE_CYCLES differing samples can flip the output.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CntLast) begin
        stable_d = ~stable_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= raw;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable = stable_q;

endmodule

// File: rtl/pad_input_conditioner.sv
// Conditions breadboard controller lines for the game logic.
// Ports: clk, rst_n (async active-low), pad (slave modport):
//   dir_raw/btn_raw in; dir_state (one-hot, CENTER at rest), dir_change,
//   btn_level/btn_press/btn_release/btn_held, led_outputs = {btn_level, dir_state}.
// Every line is synchronised and debounced; all outputs are registered from
// the debounced values.
module pad_input_conditioner
  import pad_pkg::*;
#(
  parameter int unsigned NUM_BUTTONS     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned HOLD_CYCLES     = 50000000
) (
  input logic                    clk,
  input logic                    rst_n,
  pad_input_conditioner_if.slave pad
);

  localparam int unsigned CNT_W     = $clog2(max_u(DEBOUNCE_CYCLES, HOLD_CYCLES) + 1);
  localparam int unsigned NUM_LINES = 4 + NUM_BUTTONS;
  localparam logic [CNT_W-1:0] HoldMax = CNT_W'(HOLD_CYCLES);

  logic [NUM_LINES-1:0]   raw_lines, stable_lines;
  logic [3:0]             stable_dirs;
  logic [NUM_BUTTONS-1:0] stable_btns;

  assign raw_lines   = {pad.btn_raw, pad.dir_raw};
  assign stable_dirs = stable_lines[3:0];
  assign stable_btns = stable_lines[NUM_LINES-1:4];

  for (genvar i = 0; i < NUM_LINES; i++) begin : g_chan
    debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_chan (
      .clk    (clk),
      .rst_n  (rst_n),
      .raw    (raw_lines[i]),
      .stable (stable_lines[i])
    );
  end

  dir_t                              dir_state_q, dir_state_d;
  logic                              dir_change_q, dir_change_d;
  logic [NUM_BUTTONS-1:0]            btn_level_q, btn_level_d;
  logic [NUM_BUTTONS-1:0]            btn_press_q, btn_press_d;
  logic [NUM_BUTTONS-1:0]            btn_release_q, btn_release_d;
  logic [NUM_BUTTONS-1:0]            btn_held_q, btn_held_d;
  logic [NUM_BUTTONS-1:0][CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [DIR_W+NUM_BUTTONS-1:0]      led_q, led_d;

  always_comb begin
    dir_state_d   = encode_dir(stable_dirs);
    dir_change_d  = (dir_state_d != dir_state_q);
    btn_level_d   = stable_btns;
    btn_press_d   = stable_btns & ~btn_level_q;
    btn_release_d = ~stable_btns & btn_level_q;
    for (int unsigned b = 0; b < NUM_BUTTONS; b++) begin
      hold_cnt_d[b] = '0;
      if (btn_level_q[b]) begin
        hold_cnt_d[b] = (hold_cnt_q[b] == HoldMax) ? hold_cnt_q[b] : hold_cnt_q[b] + CNT_W'(1);
      end
      // Gated by the incoming level so held drops together with btn_release.
      btn_held_d[b] = stable_btns[b] && (hold_cnt_d[b] == HoldMax);
    end
    led_d = {btn_level_d, dir_state_d};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dir_state_q   <= DIR_CENTER;
      dir_change_q  <= 1'b0;
      btn_level_q   <= '0;
      btn_press_q   <= '0;
      btn_release_q <= '0;
      btn_held_q    <= '0;
      hold_cnt_q    <= '0;
      led_q         <= {{NUM_BUTTONS{1'b0}}, DIR_CENTER};
    end else begin
      dir_state_q   <= dir_state_d;
      dir_change_q  <= dir_change_d;
      btn_level_q   <= btn_level_d;
      btn_press_q   <= btn_press_d;
      btn_release_q <= btn_release_d;
      btn_held_q    <= btn_held_d;
      hold_cnt_q    <= hold_cnt_d;
      led_q         <= led_d;
    end
  end

  assign pad.dir_state   = dir_state_q;
  assign pad.dir_change  = dir_change_q;
  assign pad.btn_level   = btn_level_q;
  assign pad.btn_press   = btn_press_q;
  assign pad.btn_release = btn_release_q;
  assign pad.btn_held    = btn_held_q;
  assign pad.led_outputs = led_q;

endmodule

// File: tb/tb_pad_input_conditioner.sv
// Bench for pad_input_conditioner with DEBOUNCE_CYCLES=4, HOLD_CYCLES=8, 2 buttons.
module tb_pad_input_conditioner;

  localparam int NB   = 2;
  localparam int DEB  = 4;
  localparam int HOLD = 8;
  localparam int NL   = 4 + NB;

  logic clk;
  logic rst_n;

  pad_input_conditioner_if #(.NUM_BUTTONS(NB)) pad_if ();

  pad_input_conditioner #(
    .NUM_BUTTONS     (NB),
    .DEBOUNCE_CYCLES (DEB),
    .HOLD_CYCLES     (HOLD)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .pad   (pad_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: raw samples per edge, debounced line values, expected outputs.
  logic [NL-1:0]   h [DEB+2];
  logic [NL-1:0]   m_stable;
  logic [4:0]      e_dir;
  logic            e_change;
  logic [NB-1:0]   e_level, e_press, e_release, e_held;
  logic [4+NB:0]   e_led;
  int              run [NB];

  function automatic logic [4:0] m_prio(input logic [3:0] d);
    logic [4:0] r;
    r = 5'b00001;
    for (int i = 3; i >= 0; i--) if (d[i]) r = 5'b00010 << i;
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEB + 2; i++) h[i] = '0;
    m_stable  = '0;
    e_dir     = 5'b00001;
    e_change  = 1'b0;
    e_level   = '0;
    e_press   = '0;
    e_release = '0;
    e_held    = '0;
    e_led     = {{NB{1'b0}}, 5'b00001};
    for (int b = 0; b < NB; b++) run[b] = 0;
  endtask

  // Outputs after an edge reflect the debounced values from before it. A line
  // flips once its synced value (raw two edges back) has differed from the
  // debounced value for DEB consecutive edges.
  task automatic model_step();
    logic [4:0]    n_dir;
    logic [NB-1:0] n_level;
    logic          diff;
    n_dir     = m_prio(m_stable[3:0]);
    n_level   = m_stable[NL-1:4];
    e_change  = (n_dir != e_dir);
    e_press   = n_level & ~e_level;
    e_release = ~n_level & e_level;
    for (int b = 0; b < NB; b++) begin
      if (n_level[b] && e_level[b]) run[b] = (run[b] < HOLD) ? run[b] + 1 : HOLD;
      else run[b] = 0;
      e_held[b] = n_level[b] && (run[b] >= HOLD);
    end
    e_dir   = n_dir;
    e_level = n_level;
    e_led   = {n_level, n_dir};
    for (int i = DEB + 1; i > 0; i--) h[i] = h[i-1];
    h[0] = {pad_if.btn_raw, pad_if.dir_raw};
    for (int j = 0; j < NL; j++) begin
      diff = 1'b1;
      for (int i = 2; i <= DEB + 1; i++) if (h[i][j] == m_stable[j]) diff = 1'b0;
      if (diff) m_stable[j] = ~m_stable[j];
    end
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic compare_all();
    check("dir_state",   32'(pad_if.dir_state),   32'(e_dir));
    check("dir_change",  32'(pad_if.dir_change),  32'(e_change));
    check("btn_level",   32'(pad_if.btn_level),   32'(e_level));
    check("btn_press",   32'(pad_if.btn_press),   32'(e_press));
    check("btn_release", 32'(pad_if.btn_release), 32'(e_release));
    check("btn_held",    32'(pad_if.btn_held),    32'(e_held));
    check("led_outputs", 32'(pad_if.led_outputs), 32'(e_led));
  endtask

  // One clock: model advances on the active edge, DUT checked on the falling edge.
  task automatic tick();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_step();
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    rst_n          = 1'b1;
    pad_if.dir_raw = '0;
    pad_if.btn_raw = '0;

    // Asynchronous reset in the middle of the low clock phase.
    #3 rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_dir_state", 32'(pad_if.dir_state),   32'h01);
    check("rst_led",       32'(pad_if.led_outputs), 32'h01);
    check("rst_change",    32'(pad_if.dir_change),  32'h0);
    check("rst_press",     32'(pad_if.btn_press),   32'h0);
    check("rst_held",      32'(pad_if.btn_held),    32'h0);
    tick();
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    check("no_change_after_rst", 32'(pad_if.dir_change), 32'h0);

    // Debounce latency: 2 sync + 4 debounce + 1 output register.
    pad_if.btn_raw = 2'b01;
    repeat (6) tick();
    check("lat_level_early", 32'(pad_if.btn_level[0]), 32'h0);
    tick();
    check("lat_level",   32'(pad_if.btn_level[0]),   32'h1);
    check("lat_press",   32'(pad_if.btn_press[0]),   32'h1);
    check("lat_led5",    32'(pad_if.led_outputs[5]), 32'h1);
    tick();
    check("press_single", 32'(pad_if.btn_press[0]), 32'h0);

    // Hold: btn_held 8 cycles after btn_level rose.
    repeat (6) tick();
    check("held_early", 32'(pad_if.btn_held[0]), 32'h0);
    tick();
    check("held_on", 32'(pad_if.btn_held[0]), 32'h1);
    tick();

    // Release: level, held and release pulse change together.
    pad_if.btn_raw = 2'b00;
    repeat (6) tick();
    check("rel_level_early", 32'(pad_if.btn_level[0]), 32'h1);
    check("rel_held_early",  32'(pad_if.btn_held[0]),  32'h1);
    tick();
    check("rel_level",   32'(pad_if.btn_level[0]),   32'h0);
    check("rel_pulse",   32'(pad_if.btn_release[0]), 32'h1);
    check("rel_held",    32'(pad_if.btn_held[0]),    32'h0);
    tick();
    check("rel_single", 32'(pad_if.btn_release[0]), 32'h0);

    // Glitch of 3 cycles on parry is filtered.
    pad_if.btn_raw = 2'b10;
    repeat (3) tick();
    pad_if.btn_raw = 2'b00;
    repeat (10) begin
      tick();
      check("glitch_level", 32'(pad_if.btn_level[1]),   32'h0);
      check("glitch_press", 32'(pad_if.btn_press[1]),   32'h0);
      check("glitch_led6",  32'(pad_if.led_outputs[6]), 32'h0);
    end

    // Direction priority and CENTER.
    pad_if.dir_raw = 4'b0011;
    repeat (6) tick();
    check("dir_early", 32'(pad_if.dir_state), 32'h01);
    tick();
    check("dir_left",        32'(pad_if.dir_state),  32'h02);
    check("dir_left_change", 32'(pad_if.dir_change), 32'h1);
    tick();
    check("dir_change_single", 32'(pad_if.dir_change), 32'h0);
    pad_if.dir_raw = 4'b1100;
    repeat (6) tick();
    check("dir_still_left", 32'(pad_if.dir_state), 32'h02);
    tick();
    check("dir_up",        32'(pad_if.dir_state),  32'h08);
    check("dir_up_change", 32'(pad_if.dir_change), 32'h1);
    check("dir_up_led",    32'(pad_if.led_outputs), 32'h08);
    tick();
    pad_if.dir_raw = 4'b0000;
    repeat (7) tick();
    check("dir_center",        32'(pad_if.dir_state),  32'h01);
    check("dir_center_change", 32'(pad_if.dir_change), 32'h1);
    tick();

    // Reset while a button is held long.
    pad_if.btn_raw = 2'b01;
    repeat (7) tick();
    check("mh_press", 32'(pad_if.btn_press[0]), 32'h1);
    repeat (8) tick();
    check("mh_held", 32'(pad_if.btn_held[0]), 32'h1);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check("mh_rst_held",  32'(pad_if.btn_held[0]),  32'h0);
    check("mh_rst_level", 32'(pad_if.btn_level[0]), 32'h0);
    check("mh_rst_led",   32'(pad_if.led_outputs),  32'h01);
    tick();
    rst_n = 1'b1;
    repeat (6) tick();
    check("mh_press_early", 32'(pad_if.btn_press[0]), 32'h0);
    tick();
    check("mh_press_again", 32'(pad_if.btn_press[0]), 32'h1);
    repeat (7) tick();
    check("mh_held_early", 32'(pad_if.btn_held[0]), 32'h0);
    tick();
    check("mh_held_again", 32'(pad_if.btn_held[0]), 32'h1);
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
